hub75_fb_readout: RTL and testbench

HUB75_FB_READOUT -- requirements
Module: hub75_fb_readout

---
 rtl/hub75_fb_readout.sv | 109 ++++++++++
 tb/tb_hub75_fb_readout.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_fb_readout.sv
// HUB75 row readout: fetches one panel row (two 16-bit FB words per 24-bit pixel) into a
// ping-pong line buffer while the display side reads the other half.
module hub75_fb_readout #(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LOG_N_BANKS-1:0] rd_bank_addr,
  input  logic [LOG_N_ROWS-1:0]  rd_row_addr,
  input  logic                   rd_row_load,
  output logic                   rd_row_rdy,
  input  logic                   rd_row_swap,
  input  logic [LOG_N_COLS-1:0]  rd_col_addr,
  input  logic                   rd_en,
  output logic [23:0]            rd_data,
  output logic                   ctrl_pending,
  input  logic                   ctrl_boot,
  input  logic                   ctrl_active,
  output logic                   ctrl_done,
  output logic [12:0]            fb_addr,
  output logic                   fb_rden,
  input  logic [15:0]            fb_data
);

  localparam logic [LOG_N_COLS:0] CNT_LAST = (LOG_N_COLS+1)'(2*N_COLS-1);
  localparam logic [LOG_N_COLS:0] CNT_ONE  = (LOG_N_COLS+1)'(1);

  logic                   pingpong_q;
  logic                   pending_q;
  logic [LOG_N_BANKS-1:0] bank_q;
  logic [LOG_N_ROWS-1:0]  row_q;
  logic [LOG_N_COLS:0]    cnt_q;
  logic                   cap_q;
  logic                   wr_q;
  logic [LOG_N_COLS-1:0]  col_q;
  logic [15:0]            half_q;
  logic [23:0]            mem [2*N_COLS];

  logic accept_load;
  logic accept_swap;

  assign rd_row_rdy   = ~pending_q & ~wr_q;
  assign accept_load  = rd_row_load & rd_row_rdy;
  assign accept_swap  = rd_row_swap & rd_row_rdy;
  assign ctrl_pending = pending_q;
  assign ctrl_done    = ctrl_active & (cnt_q == CNT_LAST);
  assign fb_rden      = ctrl_active;
  // Even cnt fetches pixel bits [15:0], odd cnt fetches ch2 in the low byte.
  assign fb_addr      = {row_q, cnt_q[LOG_N_COLS:1], bank_q, cnt_q[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      pingpong_q <= 1'b0;
      pending_q  <= 1'b0;
      bank_q     <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      cap_q      <= 1'b0;
      wr_q       <= 1'b0;
      col_q      <= '0;
      half_q     <= '0;
    end else begin
      if (accept_swap) begin
        pingpong_q <= ~pingpong_q;
      end
      if (accept_load) begin
        pending_q <= 1'b1;
        bank_q    <= rd_bank_addr;
        row_q     <= rd_row_addr;
      end else if (ctrl_done) begin
        pending_q <= 1'b0;
      end
      if (ctrl_boot) begin
        cnt_q <= '0;
      end else if (ctrl_active) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      cap_q <= ctrl_active & ~cnt_q[0];
      wr_q  <= ctrl_active & cnt_q[0];
      if (ctrl_active) begin
        col_q <= cnt_q[LOG_N_COLS:1];
      end
      if (cap_q) begin
        half_q <= fb_data;
      end
    end
  end

  // Pingpong cannot change while a write is in flight, since wr_q holds rd_row_rdy low.
  always_ff @(posedge clk) begin
    if (wr_q) begin
      mem[{~pingpong_q, col_q}] <= {fb_data[7:0], half_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[{pingpong_q, rd_col_addr}];
    end
  end

endmodule

// File: tb/tb_hub75_fb_readout.sv
// Directed bench for hub75_fb_readout with a behavioural frame-buffer model.
module tb_hub75_fb_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  rd_bank_addr;
  logic [4:0]  rd_row_addr;
  logic        rd_row_load;
  logic        rd_row_rdy;
  logic        rd_row_swap;
  logic [5:0]  rd_col_addr;
  logic        rd_en;
  logic [23:0] rd_data;
  logic        ctrl_pending;
  logic        ctrl_boot;
  logic        ctrl_active;
  logic        ctrl_done;
  logic [12:0] fb_addr;
  logic        fb_rden;
  logic [15:0] fb_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hub75_fb_readout dut (
    .clk          (clk),
    .rst          (rst),
    .rd_bank_addr (rd_bank_addr),
    .rd_row_addr  (rd_row_addr),
    .rd_row_load  (rd_row_load),
    .rd_row_rdy   (rd_row_rdy),
    .rd_row_swap  (rd_row_swap),
    .rd_col_addr  (rd_col_addr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .ctrl_pending (ctrl_pending),
    .ctrl_boot    (ctrl_boot),
    .ctrl_active  (ctrl_active),
    .ctrl_done    (ctrl_done),
    .fb_addr      (fb_addr),
    .fb_rden      (fb_rden),
    .fb_data      (fb_data)
  );

  function automatic logic [23:0] pix(input logic b, input logic [4:0] r, input logic [5:0] c);
    logic [7:0] c8;
    logic [7:0] ch0, ch1, ch2;
    c8  = {2'b00, c};
    ch0 = c8 + {3'b000, r};
    ch1 = c8 ^ 8'h5A;
    ch2 = c8 * 8'd3 + {r, 3'b000} + {7'd0, b};
    return {ch2, ch1, ch0};
  endfunction

  function automatic logic [15:0] fb_word(input logic [12:0] a);
    logic [23:0] p;
    p = pix(a[1], a[12:8], a[7:2]);
    return a[0] ? {8'hAA, p[23:16]} : p[15:0];
  endfunction

  always @(posedge clk) begin
    if (fb_rden) fb_data <= fb_word(fb_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input logic b, input logic [4:0] r, input bit gap, input string tag);
    int k;
    int dones;
    logic [6:0]  kk;
    logic [12:0] exp_a;
    k = 0;
    dones = 0;
    ctrl_boot = 1'b1;
    tick();
    ctrl_boot = 1'b0;
    for (int cyc = 0; cyc < 1000 && k < 128; cyc++) begin
      ctrl_active = gap ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (ctrl_active) begin
        kk = k[6:0];
        exp_a = {r, kk[6:1], b, kk[0]};
        checks++;
        if (fb_addr !== exp_a || fb_rden !== 1'b1) begin
          errors++;
          $display("FAIL %s_fb_addr k=%0d: got %h rden=%b, expected %h rden=1",
                   tag, k, fb_addr, fb_rden, exp_a);
        end
        checks++;
        if (ctrl_done !== (k == 127)) begin
          errors++;
          $display("FAIL %s_done k=%0d: got %b, expected %b", tag, k, ctrl_done, (k == 127));
        end
        if (ctrl_done) dones++;
        k++;
      end else begin
        checks++;
        if (ctrl_done !== 1'b0 || fb_rden !== 1'b0) begin
          errors++;
          $display("FAIL %s_idle: got done=%b rden=%b, expected 0 0", tag, ctrl_done, fb_rden);
        end
      end
      tick();
    end
    ctrl_active = 1'b0;
    checks++;
    if (k != 128 || dones != 1) begin
      errors++;
      $display("FAIL %s_count: got reads=%0d dones=%0d, expected 128 1", tag, k, dones);
    end
    checks++;
    if (ctrl_pending !== 1'b0 || rd_row_rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: got pending=%b rdy=%b, expected 0 0",
               tag, ctrl_pending, rd_row_rdy);
    end
    tick();
    checks++;
    if (rd_row_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_rdy: got %b, expected 1", tag, rd_row_rdy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rd_bank_addr = '0; rd_row_addr = '0; rd_row_load = 1'b0; rd_row_swap = 1'b0;
    rd_col_addr = '0; rd_en = 1'b0; ctrl_boot = 1'b0; ctrl_active = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rd_row_rdy !== 1'b1 || ctrl_pending !== 1'b0 || ctrl_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got rdy=%b pending=%b done=%b, expected 1 0 0",
               rd_row_rdy, ctrl_pending, ctrl_done);
    end
    checks++;
    if (rd_data !== 24'h0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h, expected 000000", rd_data);
    end
    ctrl_active = 1'b1;
    #1;
    checks++;
    if (fb_rden !== 1'b1) begin
      errors++;
      $display("FAIL reset_rden_follow: got %b, expected 1", fb_rden);
    end
    ctrl_active = 1'b0;
    #1;
    checks++;
    if (fb_rden !== 1'b0) begin
      errors++;
      $display("FAIL reset_rden_idle: got %b, expected 0", fb_rden);
    end
    tick();
  endtask

  task automatic test_fill_and_read;
    rd_bank_addr = 1'b1; rd_row_addr = 5'd5; rd_row_load = 1'b1;
    tick();
    rd_row_load = 1'b0;
    checks++;
    if (ctrl_pending !== 1'b1 || rd_row_rdy !== 1'b0) begin
      errors++;
      $display("FAIL load_accept: got pending=%b rdy=%b, expected 1 0", ctrl_pending, rd_row_rdy);
    end
    run_fill(1'b1, 5'd5, 1'b0, "fill");
    rd_row_swap = 1'b1;
    tick();
    rd_row_swap = 1'b0;
    for (int c = 0; c < 64; c++) begin
      rd_en = 1'b1; rd_col_addr = c[5:0];
      tick();
      checks++;
      if (rd_data !== pix(1'b1, 5'd5, c[5:0])) begin
        errors++;
        $display("FAIL read_row5 col=%0d: got %h, expected %h", c, rd_data, pix(1'b1, 5'd5, c[5:0]));
      end
    end
    rd_en = 1'b0; rd_col_addr = 6'd0;
    tick();
    checks++;
    if (rd_data !== pix(1'b1, 5'd5, 6'd63)) begin
      errors++;
      $display("FAIL read_hold: got %h, expected %h", rd_data, pix(1'b1, 5'd5, 6'd63));
    end
  endtask

  task automatic test_ignored_and_gaps;
    rd_bank_addr = 1'b0; rd_row_addr = 5'd7; rd_row_load = 1'b1;
    tick();
    rd_bank_addr = 1'b1; rd_row_addr = 5'd9; rd_row_swap = 1'b1;
    tick();
    rd_row_load = 1'b0; rd_row_swap = 1'b0;
    checks++;
    if (ctrl_pending !== 1'b1) begin
      errors++;
      $display("FAIL ignored_pending: got %b, expected 1", ctrl_pending);
    end
    run_fill(1'b0, 5'd7, 1'b1, "gap");
    rd_en = 1'b1; rd_col_addr = 6'd0;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== pix(1'b1, 5'd5, 6'd0)) begin
      errors++;
      $display("FAIL swap_ignored: got %h, expected %h", rd_data, pix(1'b1, 5'd5, 6'd0));
    end
    rd_row_swap = 1'b1;
    tick();
    rd_row_swap = 1'b0;
    for (int c = 0; c < 64; c++) begin
      rd_en = 1'b1; rd_col_addr = c[5:0];
      tick();
      checks++;
      if (rd_data !== pix(1'b0, 5'd7, c[5:0])) begin
        errors++;
        $display("FAIL read_gap col=%0d: got %h, expected %h", c, rd_data, pix(1'b0, 5'd7, c[5:0]));
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_load_swap;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_bank_addr = 1'b1; rd_row_addr = 5'd3; rd_row_load = 1'b1; rd_row_swap = 1'b1;
    tick();
    rd_row_load = 1'b0; rd_row_swap = 1'b0;
    // Old side (row 5) read continuously while the new row fills the other half.
    rd_en = 1'b1; rd_col_addr = 6'd10;
    run_fill(1'b1, 5'd3, 1'b0, "ldswap");
    checks++;
    if (rd_data !== pix(1'b1, 5'd5, 6'd10)) begin
      errors++;
      $display("FAIL ldswap_user_side: got %h, expected %h", rd_data, pix(1'b1, 5'd5, 6'd10));
    end
    rd_en = 1'b0;
    rd_row_swap = 1'b1;
    tick();
    rd_row_swap = 1'b0;
    for (int c = 0; c < 64; c += 9) begin
      rd_en = 1'b1; rd_col_addr = c[5:0];
      tick();
      checks++;
      if (rd_data !== pix(1'b1, 5'd3, c[5:0])) begin
        errors++;
        $display("FAIL read_row3 col=%0d: got %h, expected %h", c, rd_data, pix(1'b1, 5'd3, c[5:0]));
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid_load;
    rd_en = 1'b1; rd_col_addr = 6'd1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== pix(1'b1, 5'd3, 6'd1)) begin
      errors++;
      $display("FAIL pre_abort_read: got %h, expected %h", rd_data, pix(1'b1, 5'd3, 6'd1));
    end
    rd_bank_addr = 1'b0; rd_row_addr = 5'd2; rd_row_load = 1'b1;
    tick();
    rd_row_load = 1'b0;
    ctrl_boot = 1'b1;
    tick();
    ctrl_boot = 1'b0;
    ctrl_active = 1'b1;
    repeat (40) tick();
    ctrl_active = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ctrl_pending !== 1'b0 || rd_row_rdy !== 1'b1 || rd_data !== 24'h0) begin
      errors++;
      $display("FAIL abort_state: got pending=%b rdy=%b data=%h, expected 0 1 000000",
               ctrl_pending, rd_row_rdy, rd_data);
    end
    rd_bank_addr = 1'b1; rd_row_addr = 5'd4; rd_row_load = 1'b1;
    tick();
    rd_row_load = 1'b0;
    run_fill(1'b1, 5'd4, 1'b0, "reload");
    rd_row_swap = 1'b1;
    tick();
    rd_row_swap = 1'b0;
    for (int c = 0; c < 64; c += 7) begin
      rd_en = 1'b1; rd_col_addr = c[5:0];
      tick();
      checks++;
      if (rd_data !== pix(1'b1, 5'd4, c[5:0])) begin
        errors++;
        $display("FAIL read_row4 col=%0d: got %h, expected %h", c, rd_data, pix(1'b1, 5'd4, c[5:0]));
      end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    fb_data = '0;
    test_reset();
    test_fill_and_read();
    test_ignored_and_gaps();
    test_load_swap();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
